// File: rtl/coram_dma_pkg.sv
// rtl/coram_dma_pkg.sv - shared state encodings and sizing helpers for the CoRAM memory DMA
package coram_dma_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_EXT_RD    = 3'd1;
  localparam logic [2:0] ST_CORE_WR   = 3'd2;
  localparam logic [2:0] ST_CORE_RD   = 3'd3;
  localparam logic [2:0] ST_CORE_WAIT = 3'd4;
  localparam logic [2:0] ST_EXT_WR    = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_REARM     = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    EXT_RD    = ST_EXT_RD,
    CORE_WR   = ST_CORE_WR,
    CORE_RD   = ST_CORE_RD,
    CORE_WAIT = ST_CORE_WAIT,
    EXT_WR    = ST_EXT_WR,
    DONE      = ST_DONE,
    REARM     = ST_REARM
  } state_e;

  // External addresses are byte addresses; one word advances by this many bytes.
  function automatic int unsigned byte_stride(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Core RAM capacity in words, wide enough to compare against 66-bit request sums.
  function automatic logic [65:0] capacity(input int unsigned addr_width);
    return 66'd1 << addr_width;
  endfunction

endpackage

// File: rtl/coram_memory_dma.sv
// rtl/coram_memory_dma.sv - word-at-a-time mover between a CoRAM core RAM and an external req/ack bus
module coram_memory_dma
  import coram_dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CORE_ADDR_WIDTH = 10,
  parameter int EXT_ADDR_WIDTH  = 64
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [EXT_ADDR_WIDTH-1:0]  ext_addr,
  input  logic [63:0]                core_addr,
  input  logic [64:0]                word_size,
  input  logic                       read_enable,
  input  logic                       write_enable,
  output logic                       ready,
  output logic                       busy,
  output logic                       err_illegal,
  output logic [CORE_ADDR_WIDTH-1:0] core_ram_addr,
  output logic [DATA_WIDTH-1:0]      core_ram_d,
  output logic                       core_ram_we,
  input  logic [DATA_WIDTH-1:0]      core_ram_q,
  output logic [EXT_ADDR_WIDTH-1:0]  ext_mem_addr,
  output logic [DATA_WIDTH-1:0]      ext_mem_wdata,
  output logic                       ext_mem_we,
  output logic                       ext_mem_req,
  input  logic                       ext_mem_ack,
  input  logic [DATA_WIDTH-1:0]      ext_mem_rdata
);

  localparam logic [65:0] CAP = capacity(CORE_ADDR_WIDTH);
  localparam logic [EXT_ADDR_WIDTH-1:0] STRIDE = EXT_ADDR_WIDTH'(byte_stride(DATA_WIDTH));

  state_e                     state_q, state_d;
  logic [CORE_ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [CORE_ADDR_WIDTH:0]   size_q, size_d;
  logic [CORE_ADDR_WIDTH-1:0] core_ptr_q, core_ptr_d;
  logic [EXT_ADDR_WIDTH-1:0]  ext_ptr_q, ext_ptr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       err_q, err_d;

  logic illegal;
  logic last;

  // Sums are taken at 66 bits so a huge core_addr cannot wrap into a legal range.
  assign illegal = (read_enable && write_enable) ||
                   ({1'b0, word_size} > CAP) ||
                   (({2'b00, core_addr} + {1'b0, word_size}) > CAP);
  assign last    = (cnt_q + (CORE_ADDR_WIDTH+1)'(1)) == size_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    core_ptr_d = core_ptr_q;
    ext_ptr_d  = ext_ptr_q;
    data_d     = data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_enable || write_enable) begin
          cnt_d      = '0;
          size_d     = word_size[CORE_ADDR_WIDTH:0];
          core_ptr_d = core_addr[CORE_ADDR_WIDTH-1:0];
          ext_ptr_d  = ext_addr;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (word_size == '0) begin
            state_d = DONE;
          end else if (write_enable) begin
            state_d = EXT_RD;
          end else begin
            state_d = CORE_RD;
          end
        end
      end
      EXT_RD: begin
        if (ext_mem_ack) begin
          data_d  = ext_mem_rdata;
          state_d = CORE_WR;
        end
      end
      CORE_WR: begin
        cnt_d      = cnt_q + (CORE_ADDR_WIDTH+1)'(1);
        core_ptr_d = core_ptr_q + CORE_ADDR_WIDTH'(1);
        ext_ptr_d  = ext_ptr_q + STRIDE;
        state_d    = last ? DONE : EXT_RD;
      end
      CORE_RD: state_d = CORE_WAIT;
      CORE_WAIT: begin
        data_d  = core_ram_q;
        state_d = EXT_WR;
      end
      EXT_WR: begin
        if (ext_mem_ack) begin
          cnt_d      = cnt_q + (CORE_ADDR_WIDTH+1)'(1);
          core_ptr_d = core_ptr_q + CORE_ADDR_WIDTH'(1);
          ext_ptr_d  = ext_ptr_q + STRIDE;
          state_d    = last ? DONE : CORE_RD;
        end
      end
      DONE: state_d = REARM;
      // A level-held enable must drop before another request can be taken.
      REARM: begin
        if (!read_enable && !write_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= '0;
      core_ptr_q <= '0;
      ext_ptr_q  <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      core_ptr_q <= core_ptr_d;
      ext_ptr_q  <= ext_ptr_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign busy          = (state_q != IDLE) && (state_q != REARM);
  assign err_illegal   = err_q;
  assign core_ram_addr = core_ptr_q;
  assign core_ram_d    = data_q;
  assign core_ram_we   = (state_q == CORE_WR);
  assign ext_mem_addr  = ext_ptr_q;
  assign ext_mem_wdata = data_q;
  assign ext_mem_we    = (state_q == EXT_WR);
  assign ext_mem_req   = (state_q == EXT_RD) || (state_q == EXT_WR);

endmodule
